// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the PC into a combinational instruction
// memory, captures {pc, instr} pairs into a small circular prefetch buffer and
// hands them to decode over a valid/ready handshake. Supports start, halt,
// branch/jump redirect with flush, and end-of-program drain.
module fetch_sequencer #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] LAST_PC  = 16'h001C,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    fetch_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready,
    output logic               busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PC_W-1:0]    buf_pc_q    [DEPTH];
    logic [INSTR_W-1:0] buf_instr_q [DEPTH];

    logic pop;
    logic push;

    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? buf_pc_q[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? buf_instr_q[rd_ptr_q] : '0;
    assign fetch_pc  = pc_q;
    assign busy      = (state_q != IDLE);
    assign pop       = out_valid & out_ready;

    // Next-state logic: halt beats redirect beats normal push/pop.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = 1'b0;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (halt) begin
            // A same-cycle pop has already been consumed by decode; the
            // flush simply discards whatever else remains.
            state_d  = IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (redirect_valid && (state_q != IDLE)) begin
            state_d  = FETCH;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = {redirect_pc[PC_W-1:1], 1'b0};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if ((count_q < CNT_W'(DEPTH)) || pop) begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        pc_d     = pc_q + PC_W'(2);
                        if (pc_q == LAST_PC) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                        pc_d    = RESET_PC;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Buffer storage; contents are don't-care while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= pc_q;
            buf_instr_q[wr_ptr_q] <= imem_instr;
        end
    end

endmodule
